vga_sync_receiver: RTL and testbench

- Sink end of the 640x480 VGA link: samples vga_h_sync/vga_v_sync/vga_R/G/B on the pixel clock.
- Measures line and frame timing, runs a lock state machine and recovers per-pixel coordinates with colour.
- Used for loopback capture and self-check of our VGA pattern sources, and as the front end for any VGA-input capture path.

---
 rtl/vga_sync_receiver.sv | 257 +++++++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// Sink side of a VGA link: measures line/frame timing, locks onto it and recovers pixel coordinates.
// Optional colour-bar self-check is built when COLOR_BAR_CHECK_EN is defined.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_OFFSET    = 144,
  parameter int V_OFFSET    = 35,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_h_sync,
  input  logic        vga_v_sync,
  input  logic        vga_R,
  input  logic        vga_G,
  input  logic        vga_B,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [7:0]  err_count,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [2:0]  pixel_rgb,
  output logic        frame_start,
  output logic [15:0] bar_err_count,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic        LP_POL     = (SYNC_POL != 0);
  localparam logic [10:0] LP_H_TOTAL = 11'(H_TOTAL);
  localparam logic [9:0]  LP_V_TOTAL = 10'(V_TOTAL);
  localparam logic [11:0] LP_H_START = 12'(H_OFFSET);
  localparam logic [11:0] LP_H_END   = 12'(H_OFFSET + H_ACTIVE);
  localparam logic [9:0]  LP_V_START = 10'(V_OFFSET);
  localparam logic [9:0]  LP_V_END   = 10'(V_OFFSET + V_ACTIVE);
  localparam logic [9:0]  LP_X_OFF   = 10'(H_OFFSET);
  localparam logic [8:0]  LP_Y_OFF   = 9'(V_OFFSET);
  localparam logic [7:0]  LP_LOCK    = 8'(LOCK_FRAMES);

  // Input stage: s1 is the registered pin sample, s2 the previous sync sample.
  logic       r_h_s1;
  logic       r_v_s1;
  logic [2:0] r_rgb_s1;
  logic       r_h_s2;
  logic       r_v_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_s1   <= 1'b0;
      r_v_s1   <= 1'b0;
      r_rgb_s1 <= 3'd0;
      r_h_s2   <= 1'b0;
      r_v_s2   <= 1'b0;
    end else begin
      r_h_s1   <= vga_h_sync;
      r_v_s1   <= vga_v_sync;
      r_rgb_s1 <= {vga_R, vga_G, vga_B};
      r_h_s2   <= r_h_s1;
      r_v_s2   <= r_v_s1;
    end
  end

  logic w_h_edge;
  logic w_v_edge;
  assign w_h_edge = (r_h_s1 == LP_POL) && (r_h_s2 != LP_POL);
  assign w_v_edge = (r_v_s1 == LP_POL) && (r_v_s2 != LP_POL);

  // Timing counters.
  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        r_h_seen;
  logic [10:0] r_line_len;
  logic [9:0]  r_frame_lines;
  logic [10:0] w_period;
  logic [9:0]  w_lines;

  assign w_period = r_h_cnt + 11'd1;
  assign w_lines  = r_v_cnt + 10'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_h_seen      <= 1'b0;
      r_line_len    <= '0;
      r_frame_lines <= '0;
    end else begin
      if (w_h_edge) begin
        r_h_cnt  <= '0;
        r_h_seen <= 1'b1;
        if (r_h_seen) r_line_len <= w_period;
      end else if (r_h_cnt != 11'h7FF) begin
        r_h_cnt <= w_period;
      end
      if (w_v_edge) begin
        r_v_cnt       <= '0;
        r_frame_lines <= w_lines;
      end else if (w_h_edge && (r_v_cnt != 10'h3FF)) begin
        r_v_cnt <= w_lines;
      end
    end
  end

  // A frame whose vsync never comes (line counter pinned) is treated like a bad line count.
  logic w_period_bad;
  logic w_lines_bad;
  logic w_v_stuck;
  logic w_mismatch;

  assign w_period_bad = w_h_edge && r_h_seen && (w_period != LP_H_TOTAL);
  assign w_lines_bad  = w_v_edge && (w_lines != LP_V_TOTAL);
  assign w_v_stuck    = !w_v_edge && (r_v_cnt == 10'h3FF);
  assign w_mismatch   = w_period_bad || w_lines_bad || w_v_stuck;

  // Lock state machine.
  state_t     r_state;
  logic [7:0] r_good;
  logic       r_locked;
  logic [7:0] r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_SEARCH;
      r_good   <= '0;
      r_locked <= 1'b0;
      r_err    <= '0;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          if (w_v_edge) begin
            r_state <= ST_CHECK;
            r_good  <= '0;
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            r_state <= ST_SEARCH;
          end else if (w_v_edge) begin
            r_good <= r_good + 8'd1;
            if ((r_good + 8'd1) >= LP_LOCK) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (w_mismatch) begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          end
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

  // h_cnt trails s1 by one clock (edge detection costs a stage), so the
  // column of the sample in s1 is h_cnt + 1, or 0 on the edge cycle itself.
  logic [11:0] w_h_pos;
  logic        w_in_h;
  logic        w_in_v;
  logic        w_pix_valid;
  logic [9:0]  w_x;
  logic [8:0]  w_y;

  assign w_h_pos     = w_h_edge ? 12'd0 : ({1'b0, r_h_cnt} + 12'd1);
  assign w_in_h      = (w_h_pos >= LP_H_START) && (w_h_pos < LP_H_END);
  assign w_in_v      = (r_v_cnt >= LP_V_START) && (r_v_cnt < LP_V_END);
  assign w_pix_valid = r_locked && w_in_h && w_in_v;
  assign w_x         = w_h_pos[9:0] - LP_X_OFF;
  assign w_y         = r_v_cnt[8:0] - LP_Y_OFF;

  // pixel_valid qualifies pixel_x/y/rgb for exactly one cycle; no back-pressure exists.
  logic       r_pixel_valid;
  logic [9:0] r_pixel_x;
  logic [8:0] r_pixel_y;
  logic [2:0] r_pixel_rgb;
  logic       r_frame_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel_valid <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_pixel_rgb   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_pixel_valid <= w_pix_valid;
      r_frame_start <= w_pix_valid && (w_x == 10'd0) && (w_y == 9'd0);
      if (w_pix_valid) begin
        r_pixel_x   <= w_x;
        r_pixel_y   <= w_y;
        r_pixel_rgb <= r_rgb_s1;
      end
    end
  end

`ifdef COLOR_BAR_CHECK_EN
  // Eight equal bars across the active width (80 pixels wide at 640).
  localparam logic [9:0] LP_BAR_W = 10'(H_ACTIVE / 8);

  function automatic logic [2:0] f_bar_rgb(input logic [9:0] idx);
    logic [2:0] rgb;
    case (idx)
      10'd0:   rgb = 3'b111;
      10'd1:   rgb = 3'b110;
      10'd2:   rgb = 3'b011;
      10'd3:   rgb = 3'b010;
      10'd4:   rgb = 3'b101;
      10'd5:   rgb = 3'b100;
      10'd6:   rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

  logic [15:0] r_bar_err;
  logic [9:0]  w_bar_idx;
  assign w_bar_idx = r_pixel_x / LP_BAR_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bar_err <= '0;
    end else if (r_pixel_valid && (r_pixel_rgb != f_bar_rgb(w_bar_idx)) &&
                 (r_bar_err != 16'hFFFF)) begin
      r_bar_err <= r_bar_err + 16'd1;
    end
  end

  assign bar_err_count = r_bar_err;
`else
  assign bar_err_count = 16'd0;
`endif

  assign locked      = r_locked;
  assign line_len    = r_line_len;
  assign frame_lines = r_frame_lines;
  assign err_count   = r_err;
  assign pixel_valid = r_pixel_valid;
  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign pixel_rgb   = r_pixel_rgb;
  assign frame_start = r_frame_start;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomized bench for vga_sync_receiver on a scaled-down raster, with a frame-level lock model
// and a pixel scoreboard fed by the source and drained by an output monitor.
module tb_vga_sync_receiver;

  localparam int HT   = 64;
  localparam int HA   = 32;
  localparam int HO   = 16;
  localparam int HS   = 8;
  localparam int VT   = 24;
  localparam int VA   = 12;
  localparam int VO   = 6;
  localparam int VS   = 2;
  localparam int LOCK = 2;
  localparam int BW   = HA / 8;
  localparam int RST_C = 30;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic vga_h_sync, vga_v_sync, vga_R, vga_G, vga_B;
  logic        locked;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic [7:0]  err_count;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic [2:0]  pixel_rgb;
  logic        frame_start;
  logic [15:0] bar_err_count;
  logic [1:0]  dbg_state;

  always #20 clk = ~clk;

  vga_sync_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_OFFSET(HO), .V_OFFSET(VO), .SYNC_POL(0), .LOCK_FRAMES(LOCK)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
    .locked(locked), .line_len(line_len), .frame_lines(frame_lines),
    .err_count(err_count), .pixel_valid(pixel_valid), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pixel_rgb(pixel_rgb), .frame_start(frame_start),
    .bar_err_count(bar_err_count), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [21:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int n_pushed = 0;
  int n_popped = 0;

  // Reference model, frame granularity: m_run < 0 waits for a vsync,
  // otherwise counts clean frames; lock holds while m_run >= LOCK.
  int m_run        = -1;
  int m_err        = 0;
  int m_bar        = 0;
  int m_prev_lines = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] bar_rgb(input int b);
    logic [2:0] t [8];
    t = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    return t[b];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic hs, input logic vs, input logic [2:0] rgb,
                             input logic rst);
    @(posedge clk);
    #1;
    vga_h_sync = hs;
    vga_v_sync = vs;
    {vga_R, vga_G, vga_B} = rgb;
    reset = rst;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"},      32'(locked), 32'd0);
    chk({tag, "_line_len"},    32'(line_len), 32'd0);
    chk({tag, "_frame_lines"}, 32'(frame_lines), 32'd0);
    chk({tag, "_err_count"},   32'(err_count), 32'd0);
    chk({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
    chk({tag, "_pixel_x"},     32'(pixel_x), 32'd0);
    chk({tag, "_pixel_y"},     32'(pixel_y), 32'd0);
    chk({tag, "_pixel_rgb"},   32'(pixel_rgb), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_bar_err"},     32'(bar_err_count), 32'd0);
  endtask

  // Point checks at chosen (frame, line, cycle) positions, sampled mid-cycle.
  task automatic point_checks(input int f, input int l, input int c);
    if (l == 1 && c == 2) begin
      chk("locked_vs_model", 32'(locked), 32'(m_run >= LOCK));
      chk("err_vs_model", 32'(err_count), 32'(m_err));
    end
    if ((f == 2 || f == 7 || f == 15) && l == 0 && c == 1)
      chk("locked_before_vsync", 32'(locked), 32'd0);
    if ((f == 2 || f == 7 || f == 15) && l == 0 && c == 2)
      chk("locked_at_vsync", 32'(locked), 32'd1);
    if (f == 2 && l == 0 && c == 2) begin
      chk("line_len_nominal", 32'(line_len), 32'(HT));
      chk("frame_lines_nominal", 32'(frame_lines), 32'(VT));
    end
    if (f == 4 && l == 4 && c == 1) chk("locked_before_short_edge", 32'(locked), 32'd1);
    if (f == 4 && l == 4 && c == 2) begin
      chk("locked_after_short", 32'(locked), 32'd0);
      chk("line_len_short", 32'(line_len), 32'(HT - 1));
      chk("err_after_short", 32'(err_count), 32'd1);
    end
    if (f == 5 && l == 1 && c == 2) chk("line_len_restored", 32'(line_len), 32'(HT));
    if (f == 9 && l == 0 && c == 2) begin
      chk("locked_after_short_frame", 32'(locked), 32'd0);
      chk("frame_lines_short", 32'(frame_lines), 32'(VT - 1));
      chk("err_after_short_frame", 32'(err_count), 32'd2);
    end
    if (f == 12 && l == 3 && c == RST_C + 1) check_all_zero("midreset");
    if (f == 12 && l == 4 && c == 2) chk("line_len_first_after_reset", 32'(line_len), 32'd0);
    if (f == 12 && l == 5 && c == 2) chk("line_len_second_after_reset", 32'(line_len), 32'(HT));
  endtask

  task automatic send_frame(input int f, input int nlines, input int short_l,
                            input int reset_l, input int corrupt);
    for (int l = 0; l < nlines; l++) begin
      int len;
      if (l == 0) begin
        if (m_run < 0) m_run = 0;
        else if (m_prev_lines != VT) begin
          if (m_run >= LOCK) m_err++;
          m_run = -1;
        end else m_run++;
      end
      len = (l == short_l) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        logic hs, vs, rst, act;
        logic [2:0] rgb;
        int x, y;
        hs  = (c < HS) ? 1'b0 : 1'b1;
        vs  = (l < VS) ? 1'b0 : 1'b1;
        act = (l >= VO) && (l < VO + VA) && (c >= HO) && (c < HO + HA);
        rst = (l == reset_l) && (c == RST_C);
        x   = c - HO;
        y   = l - VO;
        rgb = 3'($urandom_range(0, 7));
        if (act) begin
          rgb = bar_rgb(x / BW);
          if ($urandom_range(0, 63) == 0) rgb = 3'($urandom_range(0, 7));
          if (corrupt != 0 && x == 5 && y == 2) rgb = 3'b000;
        end
        if (rst) begin
          m_run = -1;
          m_err = 0;
          m_bar = 0;
        end
        drive_cycle(hs, vs, rgb, rst);
        if (act && m_run >= LOCK) begin
          exp_q.push_back({x[9:0], y[8:0], rgb});
          n_pushed++;
          if (rgb != bar_rgb(x / BW)) m_bar++;
        end
        @(negedge clk);
        point_checks(f, l, c);
      end
      if (l == short_l && m_run >= 0) begin
        if (m_run >= LOCK) m_err++;
        m_run = -1;
      end
    end
    m_prev_lines = nlines;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (pixel_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_pixel actual=(%0d,%0d,%0b) expected=none at %0t",
                 pixel_x, pixel_y, pixel_rgb, $time);
      end else begin
        logic [21:0] e;
        logic        e_fs;
        e    = exp_q.pop_front();
        e_fs = (e[21:12] == 10'd0) && (e[11:3] == 9'd0);
        n_popped++;
        chk("pixel", 32'({pixel_x, pixel_y, pixel_rgb, frame_start}), 32'({e, e_fs}));
      end
    end else if (frame_start === 1'b1) begin
      chk("frame_start_without_valid", 32'(frame_start), 32'd0);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(40 * 60000);
    n_err++;
    $display("FAIL watchdog actual=running expected=finished at %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    vga_h_sync = 1'b1;
    vga_v_sync = 1'b1;
    {vga_R, vga_G, vga_B} = 3'b000;
    repeat (3) drive_cycle(1'b1, 1'b1, 3'b000, 1'b1);
    @(negedge clk);
    check_all_zero("reset");
    repeat (4) drive_cycle(1'b1, 1'b1, 3'b000, 1'b0);

    for (int f = 0; f < 16; f++) begin
      int nl, sl, rl, cr;
      nl = (f == 8) ? VT - 1 : VT;
      sl = (f == 4) ? 3 : -1;
      rl = (f == 12) ? 3 : -1;
      cr = (f == 3) ? 1 : 0;
      send_frame(f, nl, sl, rl, cr);
    end

    repeat (2 * HT) drive_cycle(1'b1, 1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("pixels_seen", 32'(n_popped), 32'(n_pushed));
    chk("final_locked", 32'(locked), 32'(m_run >= LOCK));
    chk("final_err_count", 32'(err_count), 32'(m_err));
`ifdef COLOR_BAR_CHECK_EN
    chk("bar_err_count", 32'(bar_err_count), 32'(m_bar));
`else
    chk("bar_err_count", 32'(bar_err_count), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
